// File: rtl/mem_bridge.sv
// Memory stage bridge: turns level-held core requests into timed single-port
// SRAM accesses and returns a one-cycle completion pulse with read data.
module mem_bridge #(
    parameter int SRAM_AW     = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic [31:0]        mem_rdata,
    output logic               mem_resp,
    output logic               mem_err,
    output logic               busy,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD =
        CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_DATA,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic req;
    logic bad;

    assign req = mem_read | mem_write;
    assign bad = (mem_read & mem_write)
               | (mem_addr[1:0] != 2'b00)
               | ((mem_addr >> (SRAM_AW + 2)) != 32'd0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = mem_addr[SRAM_AW+1:2];
                    wdata_d = mem_wdata;
                    we_d    = mem_write;
                    err_d   = bad;
                    state_d = bad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (!we_q) begin
                    rdata_d = sram_rdata;
                end
                if (WAIT_STATES == 0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign sram_en    = (state_q == S_ACCESS);
    assign sram_we    = (state_q == S_ACCESS) & we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign mem_resp   = (state_q == S_RESP);
    assign mem_err    = (state_q == S_RESP) & err_q;
    assign busy       = (state_q != S_IDLE);
    assign mem_rdata  = rdata_q;

endmodule
